// File: rtl/exec_result_pipe_if.sv
// Execute-result pipe bus: issue side, operand lookup/forwarding side and writeback.
interface exec_result_pipe_if #(
  parameter int DW = 128,
  parameter int AW = 7
);
  logic              issue_valid;
  logic [DW-1:0]     result_EX;
  logic [2:0]        latency_EX;
  logic [AW-1:0]     rt_addr;
  logic              flush;
  logic [3*AW-1:0]   lookup_addr;
  logic [2:0]        fwd_hit;
  logic [3*DW-1:0]   fwd_data;
  logic              stall;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;

  modport master (
    output issue_valid, result_EX, latency_EX, rt_addr, flush, lookup_addr,
    input  fwd_hit, fwd_data, stall, wb_valid, wb_addr, wb_data
  );
  modport slave (
    input  issue_valid, result_EX, latency_EX, rt_addr, flush, lookup_addr,
    output fwd_hit, fwd_data, stall, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/exec_result_pipe.sv
// DEPTH-stage result shift pipe with writeback and 3-port forwarding/stall lookup.
// EXEC_RESULT_PIPE_FWD_EN enables forwarding; otherwise any in-flight match stalls.
module exec_result_pipe_port #(
  parameter int DEPTH = 7,
  parameter int DW    = 128,
  parameter int AW    = 7
) (
  input  logic [DEPTH:1]         v,
  input  logic [DEPTH:1][AW-1:0] rt,
  input  logic [DEPTH:1][2:0]    lat,
  input  logic [DEPTH:1][DW-1:0] data,
  input  logic [AW-1:0]          addr,
  output logic                   hit,
  output logic [DW-1:0]          dat,
  output logic                   stl
);
  logic          found;
  logic          rdy;
  logic [DW-1:0] sel;

  // Scan oldest to youngest so the youngest match overwrites; an entry at the
  // last stage is always ready, which clamps oversized latency codes.
  always_comb begin
    found = 1'b0;
    rdy   = 1'b0;
    sel   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v[k] && rt[k] == addr) begin
        found = 1'b1;
        rdy   = (4'(k) > {1'b0, lat[k]}) || (k == DEPTH);
        sel   = data[k];
      end
    end
  end

`ifdef EXEC_RESULT_PIPE_FWD_EN
  assign hit = found & rdy;
  assign dat = (found && rdy) ? sel : '0;
  assign stl = found & ~rdy;
`else
  logic unused_fwd;
  assign unused_fwd = ^{rdy, sel};
  assign hit = 1'b0;
  assign dat = '0;
  assign stl = found;
`endif
endmodule

module exec_result_pipe #(
  parameter int DEPTH = 7,
  parameter int DW    = 128,
  parameter int AW    = 7
) (
  input  logic clk,
  input  logic rst_n,
  exec_result_pipe_if.slave bus
);
  logic [DEPTH:1]         v_q, v_d;
  logic [DEPTH:1][AW-1:0] rt_q, rt_d;
  logic [DEPTH:1][2:0]    lat_q, lat_d;
  logic [DEPTH:1][DW-1:0] data_q, data_d;

  // Flush kills every valid bit at the edge, including the one being issued.
  always_comb begin
    v_d[1]    = bus.issue_valid & ~bus.flush;
    rt_d[1]   = bus.rt_addr;
    lat_d[1]  = bus.latency_EX;
    data_d[1] = bus.result_EX;
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k]    = v_q[k-1] & ~bus.flush;
      rt_d[k]   = rt_q[k-1];
      lat_d[k]  = lat_q[k-1];
      data_d[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      rt_q   <= '0;
      lat_q  <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      rt_q   <= rt_d;
      lat_q  <= lat_d;
      data_q <= data_d;
    end
  end

  logic [2:0]         port_hit;
  logic [2:0]         port_stl;
  logic [2:0][DW-1:0] port_dat;

  for (genvar i = 0; i < 3; i++) begin : g_port
    exec_result_pipe_port #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_port (
      .v    (v_q),
      .rt   (rt_q),
      .lat  (lat_q),
      .data (data_q),
      .addr (bus.lookup_addr[i*AW +: AW]),
      .hit  (port_hit[i]),
      .dat  (port_dat[i]),
      .stl  (port_stl[i])
    );
  end

  assign bus.fwd_hit  = port_hit;
  assign bus.fwd_data = port_dat;
  assign bus.stall    = |port_stl;
  assign bus.wb_valid = v_q[DEPTH];
  assign bus.wb_addr  = rt_q[DEPTH];
  assign bus.wb_data  = data_q[DEPTH];
endmodule

// File: tb/tb_exec_result_pipe.sv
// Directed bench for exec_result_pipe; expectations follow the build's forwarding macro.
module tb_exec_result_pipe;
`ifdef EXEC_RESULT_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exec_result_pipe_if bus ();
  exec_result_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.result_EX   = '0;
    bus.latency_EX  = '0;
    bus.rt_addr     = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic issue(input logic [6:0] rt, input logic [2:0] lat, input logic [127:0] d);
    bus.issue_valid = 1'b1;
    bus.result_EX   = d;
    bus.latency_EX  = lat;
    bus.rt_addr     = rt;
    bus.flush       = 1'b0;
  endtask

  task automatic look(input logic [6:0] rc, input logic [6:0] rb, input logic [6:0] ra);
    bus.lookup_addr = {rc, rb, ra};
  endtask

  task automatic do_reset();
    idle();
    look(7'd0, 7'd0, 7'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    look(7'd0, 7'd0, 7'd0);
    #3;
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_addr",  bus.wb_addr, 0);
    chk("rst_wb_data",  bus.wb_data, 0);
    chk("rst_fwd_hit",  bus.fwd_hit, 0);
    chk("rst_fwd_data", bus.fwd_data[127:0], 0);
    chk("rst_stall",    bus.stall, 0);

    // T1 single issue, RA=5
    do_reset();
    look(7'd0, 7'd0, 7'd5);
    for (int t = 0; t <= 8; t++) begin
      if (t == 0) issue(7'd5, 3'd2, 128'hA5); else idle();
      #4;
      chk($sformatf("t1_stall_%0d", t), bus.stall,
          FWD ? (t == 1 || t == 2) : (t >= 1 && t <= 7));
      chk($sformatf("t1_hit_%0d", t), bus.fwd_hit[0], FWD && t >= 3 && t <= 7);
      chk($sformatf("t1_data_%0d", t), bus.fwd_data[127:0],
          (FWD && t >= 3 && t <= 7) ? 128'hA5 : 128'h0);
      chk($sformatf("t1_wbv_%0d", t), bus.wb_valid, t == 7);
      if (t == 7) begin
        chk("t1_wb_addr", bus.wb_addr, 5);
        chk("t1_wb_data", bus.wb_data, 128'hA5);
      end
      next_cycle();
    end

    // T2 same-rt ordering, RB=9
    do_reset();
    look(7'd0, 7'd9, 7'd0);
    for (int t = 0; t <= 8; t++) begin
      if (t == 0) issue(7'd9, 3'd0, 128'h11);
      else if (t == 1) issue(7'd9, 3'd5, 128'h22);
      else idle();
      #4;
      chk($sformatf("t2_stall_%0d", t), bus.stall,
          FWD ? (t >= 2 && t <= 6) : (t >= 1 && t <= 8));
      chk($sformatf("t2_hit_%0d", t), bus.fwd_hit[1], FWD && (t == 1 || t >= 7));
      chk($sformatf("t2_data_%0d", t), bus.fwd_data[255:128],
          !FWD ? 128'h0 : (t == 1) ? 128'h11 : (t >= 7) ? 128'h22 : 128'h0);
      chk($sformatf("t2_wbv_%0d", t), bus.wb_valid, t == 7 || t == 8);
      if (t >= 7) chk($sformatf("t2_wbd_%0d", t), bus.wb_data, (t == 7) ? 128'h11 : 128'h22);
      next_cycle();
    end

    // T3 flush together with a new issue
    do_reset();
    look(7'd0, 7'd4, 7'd3);
    for (int t = 0; t <= 10; t++) begin
      if (t == 0) issue(7'd3, 3'd7, 128'h33);
      else if (t == 2) begin
        issue(7'd4, 3'd7, 128'h44);
        bus.flush = 1'b1;
      end else idle();
      #4;
      chk($sformatf("t3_stall_%0d", t), bus.stall, t == 1 || t == 2);
      chk($sformatf("t3_wbv_%0d", t), bus.wb_valid, 0);
      next_cycle();
    end

    // T4 asynchronous reset mid-flight
    do_reset();
    look(7'd0, 7'd11, 7'd10);
    for (int t = 0; t <= 3; t++) begin
      issue(7'(10 + t), (t == 0) ? 3'd0 : 3'd7, 128'(16 + t));
      if (t < 3) next_cycle();
    end
    #2;
    chk("t4_pre_stall", bus.stall, 1);
    chk("t4_pre_hit",   bus.fwd_hit[0], FWD);
    chk("t4_pre_data",  bus.fwd_data[127:0], FWD ? 128'h10 : 128'h0);
    rst_n = 1'b0;
    idle();
    #1;
    chk("t4_rst_stall", bus.stall, 0);
    chk("t4_rst_hit",   bus.fwd_hit, 0);
    chk("t4_rst_wbv",   bus.wb_valid, 0);
    next_cycle();
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      #4;
      chk($sformatf("t4_post_wbv_%0d", t), bus.wb_valid, 0);
      chk($sformatf("t4_post_stall_%0d", t), bus.stall, 0);
      next_cycle();
    end

    // T5 latency code beyond depth clamps to last stage, RC=2
    do_reset();
    look(7'd2, 7'd0, 7'd0);
    for (int t = 0; t <= 8; t++) begin
      if (t == 0) issue(7'd2, 3'd7, 128'hC3); else idle();
      #4;
      chk($sformatf("t5_stall_%0d", t), bus.stall,
          FWD ? (t >= 1 && t <= 6) : (t >= 1 && t <= 7));
      chk($sformatf("t5_hit_%0d", t), bus.fwd_hit[2], FWD && t == 7);
      chk($sformatf("t5_data_%0d", t), bus.fwd_data[383:256],
          (FWD && t == 7) ? 128'hC3 : 128'h0);
      chk($sformatf("t5_wbv_%0d", t), bus.wb_valid, t == 7);
      if (t == 7) chk("t5_wb_addr", bus.wb_addr, 2);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
